// File: rtl/and_unit_sequencer_if.sv
// rtl/and_unit_sequencer_if.sv - operand and result handshake bundle for the AND unit sequencer
interface and_unit_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport master (
        output in_valid, a_in, b_in, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, a_in, b_in, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/and_unit_sequencer.sv
// rtl/and_unit_sequencer.sv - launches operands into the AND unit, waits a settle time,
// captures and self-checks the result, and hands it downstream
module and_unit_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    and_unit_sequencer_if.slave bus,
    output logic [WIDTH-1:0]    a_out,
    output logic [WIDTH-1:0]    b_out,
    input  logic [WIDTH-1:0]    result_in,
    output logic                mismatch,
    output logic                busy,
    output logic [7:0]          txn_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             mismatch_q, mismatch_d;
    logic [7:0]       txn_q, txn_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        mismatch_d = mismatch_q;
        txn_d      = txn_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // result_in is only trusted here, after the AND unit has settled
                    res_d   = result_in;
                    txn_d   = txn_q + 8'd1;
                    state_d = S_HOLD;
                    if (result_in != (a_q & b_q)) begin
                        mismatch_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            mismatch_q <= 1'b0;
            txn_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            mismatch_q <= mismatch_d;
            txn_q      <= txn_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_data  = res_q;
    assign a_out         = a_q;
    assign b_out         = b_q;
    assign mismatch      = mismatch_q;
    assign busy          = (state_q != S_IDLE);
    assign txn_count     = txn_q;

endmodule

// File: tb/tb_and_unit_sequencer.sv
// tb/tb_and_unit_sequencer.sv - directed self-checking bench for and_unit_sequencer
`timescale 1ns/1ps
module tb_and_unit_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] result_in;
    logic       mismatch;
    logic       busy;
    logic [7:0] txn_count;
    logic       fault_en;
    logic [3:0] fault_val;

    int total;
    int bad;

    and_unit_sequencer_if #(.WIDTH(4)) bus ();

    and_unit_sequencer #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .a_out     (a_out),
        .b_out     (b_out),
        .result_in (result_in),
        .mismatch  (mismatch),
        .busy      (busy),
        .txn_count (txn_count)
    );

    // andckt stand-in, with an override for the faulty-unit scenario
    assign result_in = fault_en ? fault_val : (a_out & b_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'($urandom);
        bus.a_in      = 4'($urandom);
        bus.b_in      = 4'($urandom);
        bus.res_ready = 1'($urandom);
        repeat (3) tick();
        total++; if (a_out !== 4'b0000) begin bad++; $display("FAIL reset_a_out got=%b exp=0000", a_out); end
        total++; if (b_out !== 4'b0000) begin bad++; $display("FAIL reset_b_out got=%b exp=0000", b_out); end
        total++; if (bus.res_data !== 4'b0000) begin bad++; $display("FAIL reset_res_data got=%b exp=0000", bus.res_data); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (txn_count !== 8'd0) begin bad++; $display("FAIL reset_txn_count got=%0d exp=0", txn_count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bus.in_valid  = 1'b1;
        bus.a_in      = 4'b1101;
        bus.b_in      = 4'b1010;
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (a_out !== 4'b1101) begin bad++; $display("FAIL basic_a_out got=%b exp=1101", a_out); end
        total++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b/%b exp=1/0", busy, bus.in_ready); end
        tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", bus.res_valid); end
        tick();
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL basic_res_valid got=%b exp=1", bus.res_valid); end
        total++; if (bus.res_data !== 4'b1000) begin bad++; $display("FAIL basic_res_data got=%b exp=1000", bus.res_data); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL basic_mismatch got=%b exp=0", mismatch); end
        total++; if (txn_count !== 8'd1) begin bad++; $display("FAIL basic_txn_count got=%0d exp=1", txn_count); end
        tick();
        total++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got busy=%b valid=%b exp=0/0", busy, bus.res_valid); end
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a_in      = 4'b0110;
        bus.b_in      = 4'b1011;
        tick();
        bus.a_in = 4'b1111;
        bus.b_in = 4'b1111;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.res_data !== 4'b0010 || bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_data[%0d] got=%b v=%b exp=0010 v=1", i, bus.res_data, bus.res_valid); end
            total++; if (bus.in_ready !== 1'b0 || a_out !== 4'b0110) begin bad++; $display("FAIL bp_hold_in[%0d] got rdy=%b a=%b exp=0/0110", i, bus.in_ready, a_out); end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || a_out !== 4'b0110) begin bad++; $display("FAIL bp_release got busy=%b a=%b exp=0/0110", busy, a_out); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (a_out !== 4'b1111 || b_out !== 4'b1111) begin bad++; $display("FAIL bp_next_accept got=%b/%b exp=1111/1111", a_out, b_out); end
        repeat (2) tick();
        total++; if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1111) begin bad++; $display("FAIL bp_next_result got=%b v=%b exp=1111 v=1", bus.res_data, bus.res_valid); end
        total++; if (txn_count !== 8'd3) begin bad++; $display("FAIL bp_txn_count got=%0d exp=3", txn_count); end
        tick();
    endtask

    task automatic test_fault();
        fault_en      = 1'b1;
        fault_val     = 4'b1101;
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a_in      = 4'b1101;
        bus.b_in      = 4'b1100;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        total++; if (bus.res_data !== 4'b1101) begin bad++; $display("FAIL fault_res_data got=%b exp=1101", bus.res_data); end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL fault_mismatch got=%b exp=1", mismatch); end
        tick();
        fault_en     = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in     = 4'b0011;
        bus.b_in     = 4'b0101;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        total++; if (bus.res_data !== 4'b0001) begin bad++; $display("FAIL fault_next_data got=%b exp=0001", bus.res_data); end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b exp=1", mismatch); end
        total++; if (txn_count !== 8'd5) begin bad++; $display("FAIL fault_txn_count got=%0d exp=5", txn_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a_in      = 4'b1111;
        bus.b_in      = 4'b0101;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (a_out !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got a=%b busy=%b exp=0000/0", a_out, busy); end
        total++; if (txn_count !== 8'd0 || mismatch !== 1'b0) begin bad++; $display("FAIL mid_async_cnt got=%0d m=%b exp=0/0", txn_count, mismatch); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_after[%0d] got v=%b rdy=%b exp=0/1", i, bus.res_valid, bus.in_ready); end
        end
        total++; if (txn_count !== 8'd0 || a_out !== 4'b0000) begin bad++; $display("FAIL mid_final got cnt=%0d a=%b exp=0/0000", txn_count, a_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops;
        logic [7:0] exp_cnt;
        int         errs;
        errs          = 0;
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ops      = 8'(i);
            exp_cnt  = 8'(i + 1);
            bus.a_in = ops[3:0];
            bus.b_in = ops[7:4];
            tick();
            if (a_out !== ops[3:0] || b_out !== ops[7:4]) errs++;
            tick();
            tick();
            if (bus.res_valid !== 1'b1 || bus.res_data !== (ops[3:0] & ops[7:4]) || txn_count !== exp_cnt) begin
                errs++;
                if (errs < 5) $display("FAIL b2b_txn[%0d] got d=%b cnt=%0d exp d=%b cnt=%0d", i, bus.res_data, txn_count, ops[3:0] & ops[7:4], exp_cnt);
            end
            tick();
            if (bus.in_ready !== 1'b1) errs++;
        end
        bus.in_valid = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_stream got errors=%0d exp=0", errs); end
        total++; if (txn_count !== 8'd0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", txn_count); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL b2b_mismatch got=%b exp=0", mismatch); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        fault_en  = 1'b0;
        fault_val = 4'b0000;
        test_reset();
        test_basic();
        test_backpressure();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
